// File: rtl/pwm_gen_if.sv
// ---------------------------------------------------------------------------
// pwm_gen_if
//   Submit channel between an upstream duty-code source and pwm_gen.
//
//   Signals:
//     comb_waveform  WIDTH  duty code offered by the source
//     ready          1      submit strobe, sampled once per rising clk edge
//
//   Modports:
//     master  the duty-code source (drives both signals)
//     slave   pwm_gen (samples both signals)
// ---------------------------------------------------------------------------
interface pwm_gen_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] comb_waveform;
  logic             ready;

  modport master (
    output comb_waveform,
    output ready
  );

  modport slave (
    input comb_waveform,
    input ready
  );
endinterface

// File: rtl/pwm_gen.sv
// ---------------------------------------------------------------------------
// pwm_gen
//   Single-channel pulse-width modulator with a period of 2^WIDTH clocks.
//   A submitted duty code is parked in a pending register and copied into
//   the active register only on the wrap edge, so each period is produced
//   from one stable duty value and the output never glitches mid-period.
//
//   Ports:
//     clk    in   system clock, rising edge
//     n_rst  in   asynchronous reset, asserted HIGH despite the name
//     bus    in   pwm_gen_if.slave: comb_waveform (duty code) + ready strobe
//     pwm_o  out  registered PWM output; high while cnt < active
// ---------------------------------------------------------------------------
module pwm_gen #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          n_rst,
  pwm_gen_if.slave      bus,
  output logic          pwm_o
);

  localparam logic [WIDTH-1:0] CNT_LAST = '1;

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] active;

  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] pending_next;
  logic [WIDTH-1:0] active_next;
  logic             wrap;
  logic             pwm_next;

  // Next-state logic. The output compare uses the values being written on
  // this edge, so in the cycle where cnt=n the output is (n < active). That
  // makes the pulse start exactly at cnt=0 of every period.
  always_comb begin
    // NOTE: every signal gets a default before any conditional assignment,
    // otherwise a missed branch would infer a latch.
    cnt_next     = cnt + WIDTH'(1);
    pending_next = pending;
    active_next  = active;
    wrap         = (cnt == CNT_LAST);

    if (bus.ready) begin
      pending_next = bus.comb_waveform;
    end

    // A submit on the wrap edge itself bypasses pending so it still lands
    // in the very next period.
    if (wrap) begin
      active_next = bus.ready ? bus.comb_waveform : pending;
    end

    pwm_next = (cnt_next < active_next);
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      cnt     <= '0;
      pending <= '0;
      active  <= '0;
      pwm_o   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every register
      // samples the pre-edge values, independent of statement order.
      cnt     <= cnt_next;
      pending <= pending_next;
      active  <= active_next;
      pwm_o   <= pwm_next;
    end
  end

endmodule

// File: tb/tb_pwm_gen.sv
// ---------------------------------------------------------------------------
// tb_pwm_gen
//   Directed bench for pwm_gen. Each clock, the expected output computed by
//   a small behavioural model is pushed to a scoreboard queue and popped for
//   comparison one time unit after the edge. Period-level high-cycle counts
//   are checked against fixed duty constants.
// ---------------------------------------------------------------------------
module tb_pwm_gen;

  logic clk = 1'b0;
  logic n_rst = 1'b1;
  logic pwm_o;

  always #5 clk = ~clk;

  pwm_gen_if #(.WIDTH(8)) bus ();

  pwm_gen #(.WIDTH(8)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus),
    .pwm_o (pwm_o)
  );

  int   total = 0;
  int   bad   = 0;
  int   hi    = 0;
  int   cyc   = 0;
  logic exp_q[$];

  // Behavioural model state: counter, last submitted code, code in effect.
  logic [7:0] m_cnt  = 8'd0;
  logic [7:0] m_pend = 8'd0;
  logic [7:0] m_act  = 8'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 8'd0;
    m_pend = 8'd0;
    m_act  = 8'd0;
    exp_q.delete();
  endtask

  // One clock: drive inputs at negedge, update model at posedge, then pop
  // the scoreboard and compare shortly after the edge.
  task automatic cycle(input logic r, input logic [7:0] v);
    logic e;
    @(negedge clk);
    bus.ready         = r;
    bus.comb_waveform = v;
    @(posedge clk);
    if (m_cnt == 8'd255) m_act = r ? v : m_pend;
    if (r) m_pend = v;
    m_cnt = m_cnt + 8'd1;
    exp_q.push_back(m_cnt < m_act);
    #1;
    e = exp_q.pop_front();
    check($sformatf("pwm cyc=%0d cnt=%0d", cyc, m_cnt), {31'd0, pwm_o}, {31'd0, e});
    if (pwm_o === 1'b1) hi++;
    cyc++;
  endtask

  task automatic run(input int n, input logic r, input logic [7:0] v);
    repeat (n) cycle(r, v);
  endtask

  // One full period starting from the wrap edge (model at cnt=255 before).
  task automatic period(input logic first_r, input logic [7:0] first_v,
                        input logic [7:0] rest_v, input int exp_hi, input string tag);
    hi = 0;
    cycle(first_r, first_v);
    run(255, 1'b0, rest_v);
    check(tag, hi, exp_hi);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ready         = 1'b0;
    bus.comb_waveform = 8'd0;
    n_rst             = 1'b1;
    model_reset();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset pwm_o", {31'd0, pwm_o}, 32'd0);
    n_rst = 1'b0;

    // First load: 130 strobed once, 100 presented unstrobed afterwards.
    hi = 0;
    cycle(1'b1, 8'd130);
    run(254, 1'b0, 8'd100);
    check("first load low before wrap", hi, 0);
    period(1'b0, 8'd100, 8'd100, 130, "duty 130 period 1");
    period(1'b0, 8'd100, 8'd100, 130, "duty 130 period 2");

    // Unstrobed change mid-stream is ignored.
    period(1'b0, 8'd26, 8'd26, 130, "unstrobed 26 ignored");

    // Maximum duty submitted mid-period.
    hi = 0;
    run(20, 1'b0, 8'd26);
    cycle(1'b1, 8'd255);
    run(235, 1'b0, 8'd26);
    check("period before 255 applies", hi, 130);
    period(1'b0, 8'd0, 8'd0, 255, "duty 255 period 1");
    period(1'b0, 8'd0, 8'd0, 255, "duty 255 period 2");
    check("duty 255 low at cnt 255", {31'd0, pwm_o}, 32'd0);

    // Wrap-edge collision: pending 50, then 200 submitted on the wrap edge.
    hi = 0;
    run(10, 1'b0, 8'd0);
    cycle(1'b1, 8'd50);
    run(245, 1'b0, 8'd9);
    check("period holding 255 with 50 pending", hi, 255);
    period(1'b1, 8'd200, 8'd0, 200, "collision 200 applied");
    period(1'b0, 8'd0, 8'd0, 200, "collision 50 never applied");

    // Zero duty submitted mid-period.
    hi = 0;
    run(100, 1'b0, 8'd0);
    cycle(1'b1, 8'd0);
    run(155, 1'b0, 8'd0);
    check("period before zero applies", hi, 200);
    period(1'b0, 8'd0, 8'd0, 0, "duty 0 period 1");
    period(1'b0, 8'd0, 8'd0, 0, "duty 0 period 2");

    // Submit on the wrap edge from zero duty, then reset mid-period while high.
    period(1'b1, 8'd77, 8'd0, 77, "wrap submit 77");
    run(10, 1'b0, 8'd0);
    check("pwm_o high before reset", {31'd0, pwm_o}, 32'd1);
    @(negedge clk);
    #2;
    n_rst = 1'b1;
    model_reset();
    #1;
    check("async reset drops pwm_o", {31'd0, pwm_o}, 32'd0);
    @(posedge clk);
    #1;
    check("pwm_o held low in reset", {31'd0, pwm_o}, 32'd0);
    n_rst = 1'b0;

    // Idle after reset: pending code lost, output low for 512 cycles.
    hi = 0;
    run(512, 1'b0, 8'd0);
    check("idle 512 cycles after reset", hi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
